// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - stall/flush/valid controller for the 5-stage LC-3b pipeline
// Optional stall/flush counters: define PIPE_CTRL_PERF_EN.
module pipe_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        imem_resp,
  input  logic        dmem_req,
  input  logic        dmem_resp,
  input  logic        br_taken,
  input  logic [15:0] id_ir,
  input  logic        ex_is_load,
  input  logic [2:0]  ex_dest,
  output logic        pc_load,
  output logic        if_id_load,
  output logic        id_ex_load,
  output logic        ex_mem_load,
  output logic        mem_wb_load,
  output logic        if_id_valid,
  output logic        id_ex_valid,
  output logic        ex_mem_valid,
  output logic        mem_wb_valid
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [15:0] perf_dstall,
  output logic [15:0] perf_istall,
  output logic [15:0] perf_bubble,
  output logic [15:0] perf_flush
`endif
);

  typedef enum logic [2:0] {
    C_DSTALL, C_BR_WAIT, C_FLUSH, C_LUH, C_IWAIT, C_RUN
  } cond_e;

  cond_e      cond;
  logic       v_ifid, v_idex, v_exmem, v_memwb;
  logic       n_ifid, n_idex, n_exmem, n_memwb;
  logic       dstall, brx, luh;
  logic       use_sr1, use_sr2, use_sr;
  logic [3:0] opcode;
  logic       unused_ir_bits;

  assign opcode         = id_ir[15:12];
  assign unused_ir_bits = ^id_ir[4:3];

  always_comb begin
    use_sr1 = 1'b0;
    use_sr2 = 1'b0;
    use_sr  = 1'b0;
    case (opcode)
      4'b0001, 4'b0101: begin
        use_sr1 = 1'b1;
        use_sr2 = ~id_ir[5];
      end
      4'b1001, 4'b0010, 4'b0110, 4'b1010, 4'b1100, 4'b1101: use_sr1 = 1'b1;
      4'b0011, 4'b0111, 4'b1011: begin
        use_sr1 = 1'b1;
        use_sr  = 1'b1;
      end
      4'b0100: use_sr1 = ~id_ir[11];
      default: ;
    endcase
  end

  assign dstall = v_exmem & dmem_req & ~dmem_resp;
  assign brx    = v_exmem & br_taken;
  assign luh    = v_ifid & v_idex & ex_is_load &
                  ((use_sr1 & (id_ir[8:6]  == ex_dest)) |
                   (use_sr2 & (id_ir[2:0]  == ex_dest)) |
                   (use_sr  & (id_ir[11:9] == ex_dest)));

  always_comb begin
    if (dstall)                  cond = C_DSTALL;
    else if (brx && !imem_resp)  cond = C_BR_WAIT;
    else if (brx)                cond = C_FLUSH;
    else if (luh)                cond = C_LUH;
    else if (!imem_resp)         cond = C_IWAIT;
    else                         cond = C_RUN;
  end

  always_comb begin
    pc_load     = 1'b0;
    if_id_load  = 1'b0;
    id_ex_load  = 1'b0;
    ex_mem_load = 1'b0;
    mem_wb_load = 1'b0;
    n_ifid      = v_ifid;
    n_idex      = v_idex;
    n_exmem     = v_exmem;
    n_memwb     = v_memwb;
    case (cond)
      C_DSTALL, C_BR_WAIT: ;
      C_FLUSH: begin
        {pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load} = 5'b11111;
        {n_ifid, n_idex, n_exmem, n_memwb} = 4'b0001;
      end
      C_LUH: begin
        {id_ex_load, ex_mem_load, mem_wb_load} = 3'b111;
        n_idex  = 1'b0;
        n_exmem = v_idex;
        n_memwb = v_exmem;
      end
      C_IWAIT: begin
        // IF/ID moves on even without a new fetch, so it must be marked empty
        {id_ex_load, ex_mem_load, mem_wb_load} = 3'b111;
        n_ifid  = 1'b0;
        n_idex  = v_ifid;
        n_exmem = v_idex;
        n_memwb = v_exmem;
      end
      default: begin
        {pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load} = 5'b11111;
        n_ifid  = 1'b1;
        n_idex  = v_ifid;
        n_exmem = v_idex;
        n_memwb = v_exmem;
      end
    endcase
    if (reset) begin
      {pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load} = 5'b00000;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      {v_ifid, v_idex, v_exmem, v_memwb} <= 4'b0000;
    end else begin
      {v_ifid, v_idex, v_exmem, v_memwb} <= {n_ifid, n_idex, n_exmem, n_memwb};
    end
  end

  assign if_id_valid  = v_ifid;
  assign id_ex_valid  = v_idex;
  assign ex_mem_valid = v_exmem;
  assign mem_wb_valid = v_memwb;

`ifdef PIPE_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_dstall <= 16'h0000;
      perf_istall <= 16'h0000;
      perf_bubble <= 16'h0000;
      perf_flush  <= 16'h0000;
    end else begin
      if (cond == C_DSTALL && perf_dstall != 16'hFFFF) perf_dstall <= perf_dstall + 16'd1;
      if ((cond == C_BR_WAIT || cond == C_IWAIT) && perf_istall != 16'hFFFF)
        perf_istall <= perf_istall + 16'd1;
      if (cond == C_LUH && perf_bubble != 16'hFFFF) perf_bubble <= perf_bubble + 16'd1;
      if (cond == C_FLUSH && perf_flush != 16'hFFFF) perf_flush <= perf_flush + 16'd1;
    end
  end
`endif

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central stall/flush/valid controller for the 5-stage LC-3b pipeline.
- Drives the load enables of the PC and the four pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Tracks a valid bit per pipeline register. Datapath gates register-file writes, memory requests and branch resolution with these bits.
- Resolves instruction-memory waits, data-memory waits, load-use hazards and taken control transfers with a fixed priority.

Parameters:
- none; widths fixed by lc3b_types (16-bit instruction, 3-bit register index)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- imem_resp  in  1  instruction fetch for current PC completes this cycle
- dmem_req  in  1  MEM-stage instruction requests data memory (read or write)
- dmem_resp  in  1  data memory completes MEM-stage access this cycle
- br_taken  in  1  MEM-stage instruction resolved as taken BR/JMP/JSR/JSRR/TRAP
- id_ir  in  16  instruction held in IF/ID
- ex_is_load  in  1  ID/EX instruction is LDR/LDB/LDI (writes a register from memory)
- ex_dest  in  3  destination register of ID/EX instruction
- pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load  out  1 each  register load enables
- if_id_valid, id_ex_valid, ex_mem_valid, mem_wb_valid  out  1 each  registered valid bits

Behaviour:
- Valid bits v_ifid/v_idex/v_exmem/v_memwb are flops. Reset value 0.
- While reset=1, all load outputs are 0.
- Load outputs are combinational from inputs and the valid flops. Zero-cycle latency.
- Qualified terms:
  - dstall = v_exmem & dmem_req & ~dmem_resp
  - brx = v_exmem & br_taken
  - luh = v_ifid & v_idex & ex_is_load & (dest matches a source of id_ir)
- Source decode by opcode id_ir[15:12]:
  - SR1 = id_ir[8:6]: ADD 0001, AND 0101, NOT 1001, LDB 0010, LDR 0110, LDI 1010, STB 0011, STR 0111, STI 1011, JMP 1100, SHF 1101, JSRR (0100 with id_ir[11]=0).
  - SR2 = id_ir[2:0]: ADD/AND with id_ir[5]=0.
  - SR = id_ir[11:9]: STB/STR/STI.
  - All other opcodes: no sources.
- Priority, evaluated each cycle (first matching case wins):
  1. dstall: all loads 0; valid bits unchanged (full freeze).
  2. brx & ~imem_resp: all loads 0; valid bits unchanged. Wait for the in-flight fetch to retire before redirect.
  3. brx & imem_resp:
     - all loads 1; PC takes the target (datapath select from br_taken).
     - v_memwb<=1; v_ifid<=0, v_idex<=0, v_exmem<=0 (squash three younger instructions).
  4. luh:
     - pc_load=0, if_id_load=0; id_ex_load=ex_mem_load=mem_wb_load=1.
     - v_idex<=0 (bubble); v_exmem<=v_idex; v_memwb<=v_exmem; v_ifid unchanged.
  5. ~imem_resp:
     - pc_load=0, if_id_load=0; others 1.
     - v_idex<=v_ifid, v_ifid<=0 (IF/ID consumed, not duplicated); v_exmem<=v_idex; v_memwb<=v_exmem.
  6. else: all loads 1; v_ifid<=1, v_idex<=v_ifid, v_exmem<=v_idex, v_memwb<=v_exmem.
- Valid outputs are the flops directly.
- After reset the pipe fills one stage per advancing cycle. First fetched instruction reaches mem_wb_valid=1 four advancing cycles after its fetch.
- Reset mid-stall: valid bits cleared next edge. No stall or flush state survives reset.
- Invalid stages never cause stalls or flushes (all terms qualified by valid).

Optional Feature:
- Macro PIPE_CTRL_PERF_EN.
- Defined: adds four 16-bit outputs perf_dstall, perf_istall, perf_bubble, perf_flush.
  - Each increments by 1 on every cycle case 1, case 2 or 5, case 4, and case 3 respectively fires.
  - Each saturates at 16'hFFFF and is cleared by reset.
- Undefined: ports and counters are absent. Core behaviour is identical.

Test Plan:
- Reset then imem_resp=1 steady, NOP stream, dmem_req=0 -> valid bits fill 1000,1100,1110,1111 (ifid..memwb) over 4 cycles; all loads 1 throughout.
- Full pipe, dmem_req=1 with dmem_resp=0 for 3 cycles then 1 -> all loads 0 for 3 cycles, valids unchanged; 4th cycle all loads 1 and shift.
- ID/EX holds LDR R2 (v_idex=1), IF/ID holds ADD R1,R2,R3 -> one cycle pc_load=if_id_load=0, id_ex_valid=0 next; following cycle all loads 1. Same with ex_dest=R4: no stall.
- br_taken=1 with v_exmem=1 and imem_resp=0 for 2 cycles then 1 -> 2 freeze cycles; then all loads 1, next state valids 0,0,0,1.
- Full pipe, imem_resp=0 for 2 cycles -> cycle 1: id_ex_valid<=1, if_id_valid<=0; cycle 2: id_ex_valid<=0 (bubble); no instruction duplicated.
- PIPE_CTRL_PERF_EN: force 70000 dstall cycles -> perf_dstall=16'hFFFF; reset -> 0.
